// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory responder.
package slc3_mem_pkg;

    // Default address of the memory-mapped switch/hex word.
    localparam logic [15:0] DEF_IO_ADDR = 16'hFFFF;

    // Width of the wait-state counter; WAIT_STATES must fit in it.
    localparam int CNT_W = 4;

    // Transaction sequencing states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        ACCESS  = 3'd2,
        DONE    = 3'd3,
        RELEASE = 3'd4
    } mem_state_t;

    // Latched operation kind.
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } mem_op_t;

    // Target of a latched address.
    typedef enum logic [1:0] {
        RAM      = 2'd0,
        IO       = 2'd1,
        UNMAPPED = 2'd2
    } mem_region_t;

endpackage

// File: rtl/sram_sync_1p.sv
// Single-port synchronous RAM: registered read, write-enable, no reset.
module sram_sync_1p #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // One access per enabled cycle; read data appears after the edge.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the SLC-3 CPU: sequences one access per
// request through fixed wait states, decodes RAM / switch-hex I/O /
// unmapped space, and pulses Mem_Ready for one cycle on completion.
module mem_responder
    import slc3_mem_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = DEF_IO_ADDR
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Mem_Rd,
    input  logic        Mem_Wr,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic [9:0]  SW,
    output logic [15:0] MDR_In,
    output logic        Mem_Ready,
    output logic [15:0] HEX_Data,
    output logic        Err
);

    mem_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [15:0]       addr_q;
    logic [15:0]       data_q;
    mem_op_t           op_q;
    mem_region_t       region;
    logic [15:0]       fast_rd_q;   // read result for I/O / unmapped
    logic [15:0]       rd_hold;     // last completed read, shown between reads
    logic [15:0]       rd_fresh;
    logic              ram_en;
    logic              ram_we;
    logic [15:0]       ram_rdata;
    logic              req;

    assign req = Mem_Rd | Mem_Wr;

    // Address decode always works from the latched address so a CPU that
    // changes MAR mid-transaction cannot redirect the access.
    always_comb begin
        region = UNMAPPED;
        if (addr_q == IO_ADDR)
            region = IO;
        else if (addr_q[15:ADDR_W] == '0)
            region = RAM;
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and RAM strobes. RELEASE blocks a held request from
    // being taken as a second access.
    always_comb begin
        state_nxt = state;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        case (state)
            IDLE: begin
                if (req) state_nxt = (WAIT_STATES == 0) ? ACCESS : WAIT;
            end
            WAIT: begin
                if (cnt <= CNT_W'(1)) state_nxt = ACCESS;
            end
            ACCESS: begin
                ram_en    = (region == RAM);
                ram_we    = (op_q == WRITE);
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!req) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, wait counting, I/O side effects and error tracking.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt       <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            op_q      <= READ;
            fast_rd_q <= '0;
            rd_hold   <= '0;
            HEX_Data  <= '0;
            Err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q <= MAR;
                        data_q <= MDR;
                        // Simultaneous strobes resolve to a write and are flagged.
                        op_q   <= Mem_Wr ? WRITE : READ;
                        cnt    <= CNT_W'(WAIT_STATES);
                        if (Mem_Rd && Mem_Wr) Err <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                end
                ACCESS: begin
                    fast_rd_q <= (region == IO) ? {6'b0, SW} : 16'h0000;
                    if (region == IO && op_q == WRITE) HEX_Data <= data_q;
                    if (region == UNMAPPED) Err <= 1'b1;
                end
                DONE: begin
                    if (op_q == READ) rd_hold <= rd_fresh;
                end
                default: ;
            endcase
        end
    end

    // RAM read data only arrives after the ACCESS edge, so the completing
    // read is forwarded combinationally during DONE and held afterwards.
    assign rd_fresh  = (region == RAM) ? ram_rdata : fast_rd_q;
    assign MDR_In    = (state == DONE && op_q == READ) ? rd_fresh : rd_hold;
    assign Mem_Ready = (state == DONE);

    sram_sync_1p #(
        .ADDR_W (ADDR_W),
        .DATA_W (16)
    ) u_ram (
        .clk   (Clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr_q[ADDR_W-1:0]),
        .wdata (data_q),
        .rdata (ram_rdata)
    );

endmodule
